cpu_mem_responder: RTL

Unified instruction/data memory that services the CPU core's memory interface. Instruction fetch is read-only and zero-wait; the data port handles sized loads and stores with byte-lane steering. It also keeps sticky error status and access counters for the bench and for debug.
It has zero-wait reads because the core pipeline has no stall path.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_steer.sv | 38 +++
 rtl/cpu_mem_responder.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the CPU memory responder.
// funct3 size codes, the fetch filler instruction and the alignment rule.
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic type_valid(input logic [2:0] mem_type);
        case (mem_type)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // True when the address low bits are naturally aligned for the access size.
    function automatic logic size_legal(input logic [2:0] mem_type, input logic [1:0] addr_lo);
        case (mem_type)
            MEM_B, MEM_BU: return 1'b1;
            MEM_H, MEM_HU: return ~addr_lo[0];
            MEM_W:         return (addr_lo == 2'b00);
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: store byte enables and replicated write word,
// plus right-justified, zero-filled extraction for loads.
module mem_lane_steer
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be_c,
    output logic [31:0] wword_c,
    output logic [31:0] rdata_c
);

    always_comb begin
        be_c    = 4'b0000;
        wword_c = 32'h0;
        rdata_c = 32'h0;
        case (size)
            SZ_B: begin
                be_c    = 4'b0001 << addr_lo;
                wword_c = {4{wdata[7:0]}};
                rdata_c = {24'h0, rword[8*addr_lo +: 8]};
            end
            SZ_H: begin
                be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword_c = {2{wdata[15:0]}};
                rdata_c = {16'h0, (addr_lo[1] ? rword[31:16] : rword[15:0])};
            end
            default: begin
                be_c    = 4'b1111;
                wword_c = wdata;
                rdata_c = rword;
            end
        endcase
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Unified instruction/data memory for the CPU core: zero-wait fetch and
// sized loads, edge-committed stores, sticky error status and access counters.
module cpu_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = NOP
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] Instr_Addr,
    output logic [31:0] INSTRUCTION,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic        misalign_err,
    output logic        range_err,
    output logic        proto_err,
    output logic [31:0] err_addr,
    output logic [31:0] load_count,
    output logic [31:0] store_count
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] f_off, d_off, rword, wword, rdata;
    logic [3:0]  be;
    logic        f_in, d_in, access;
    logic        proto_c, mis_c, rng_c, legal_c, ld_ok_c, st_ok_c, commit_c;
    logic        abort_pending;

    assign f_off = Instr_Addr - BASE_ADDR;
    assign f_in  = (f_off < SPAN);
    assign d_off = MEM_addr - BASE_ADDR;
    assign d_in  = (d_off < SPAN);

    assign INSTRUCTION = (rst || !f_in) ? NOP_INSTR : mem[f_off[AW+1:2]];
    assign rword       = mem[d_off[AW+1:2]];

    // Access classification; an illegal size code is a protocol error, not a misalignment.
    assign access   = MEM_rd_en | MEM_wr_en;
    assign proto_c  = access && ((MEM_rd_en && MEM_wr_en) || !type_valid(MEM_type));
    assign mis_c    = access && type_valid(MEM_type) && !size_legal(MEM_type, MEM_addr[1:0]);
    assign rng_c    = access && !d_in;
    assign legal_c  = access && !proto_c && !mis_c && !rng_c;
    assign ld_ok_c  = legal_c && MEM_rd_en;
    assign st_ok_c  = legal_c && MEM_wr_en;
    assign commit_c = st_ok_c && !rst && !abort_pending;

    mem_lane_steer u_steer (
        .size    (MEM_type[1:0]),
        .addr_lo (MEM_addr[1:0]),
        .wdata   (MEM_WR_out),
        .rword   (rword),
        .be_c    (be),
        .wword_c (wword),
        .rdata_c (rdata)
    );

    assign MEM_data = (ld_ok_c && !rst) ? rdata : 32'h0;

    always_ff @(posedge CLK) begin
        if (commit_c) begin
            if (be[0]) mem[d_off[AW+1:2]][7:0]   <= wword[7:0];
            if (be[1]) mem[d_off[AW+1:2]][15:8]  <= wword[15:8];
            if (be[2]) mem[d_off[AW+1:2]][23:16] <= wword[23:16];
            if (be[3]) mem[d_off[AW+1:2]][31:24] <= wword[31:24];
        end
    end

    // A reset pulse that ends between edges aborts the access in flight at the next edge.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            abort_pending <= 1'b1;
            misalign_err  <= 1'b0;
            range_err     <= 1'b0;
            proto_err     <= 1'b0;
            err_addr      <= 32'h0;
            load_count    <= 32'h0;
            store_count   <= 32'h0;
        end else begin
            abort_pending <= 1'b0;
            if (!abort_pending) begin
                if ((proto_c || mis_c || rng_c) && !(misalign_err || range_err || proto_err))
                    err_addr <= MEM_addr;
                if (mis_c)   misalign_err <= 1'b1;
                if (rng_c)   range_err    <= 1'b1;
                if (proto_c) proto_err    <= 1'b1;
                if (ld_ok_c) load_count   <= load_count + 32'd1;
                if (st_ok_c) store_count  <= store_count + 32'd1;
            end
        end
    end

endmodule
